// File: rtl/adder_arbiter.sv
// adder_arbiter: two requesters share one 6-bit adder through a single-entry
// result register. Multi-beat chains lock the adder to one owner and forward
// the carry from one beat to the next.
module adder_arbiter #(
  parameter bit FAIR     = 1'b1,
  parameter bit CHAIN_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [5:0] req0_a,
  input  logic [5:0] req0_b,
  input  logic       req0_cin,
  input  logic       req0_last,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [5:0] req1_a,
  input  logic [5:0] req1_b,
  input  logic       req1_cin,
  input  logic       req1_last,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [5:0] res_sum,
  output logic       res_cout,
  output logic       res_id,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

  state_t state, state_nxt;
  logic   rr_last;   // index of the requester served most recently
  logic   chain_c;   // carry handed from one chained beat to the next

  logic [1:0]      vld, gnt, rdy, acc, cin, last;
  logic [1:0][5:0] a, b;
  logic            slot_free, sel, any_acc, carry, beat_last;
  logic [5:0]      op_a, op_b;
  logic [6:0]      sum7;

  assign vld  = {req1_valid, req0_valid};
  assign cin  = {req1_cin, req0_cin};
  assign last = {req1_last, req0_last};
  assign a    = {req1_a, req0_a};
  assign b    = {req1_b, req0_b};

  // Grant: a lock owner has exclusive use; otherwise pick among valid requesters.
  always_comb begin
    gnt = 2'b00;
    unique case (state)
      LOCK0:   gnt = 2'b01;
      LOCK1:   gnt = 2'b10;
      default: begin
        if (vld == 2'b11) gnt = (FAIR && !rr_last) ? 2'b10 : 2'b01;
        else              gnt = vld;
      end
    endcase
  end

  // The result slot can take a beat when empty or draining this cycle.
  assign slot_free  = !res_valid || res_ready;
  assign rdy        = rst ? 2'b00 : (gnt & {2{slot_free}});
  assign acc        = rdy & vld;
  assign any_acc    = |acc;
  assign sel        = acc[1];
  assign req0_ready = rdy[0];
  assign req1_ready = rdy[1];

  // Shared adder; chained beats take the stored carry instead of cin.
  assign op_a      = sel ? a[1] : a[0];
  assign op_b      = sel ? b[1] : b[0];
  assign carry     = (state == IDLE) ? cin[sel] : chain_c;
  assign sum7      = {1'b0, op_a} + {1'b0, op_b} + {6'd0, carry};
  assign beat_last = !CHAIN_EN || last[sel];

  assign busy = res_valid || (state != IDLE);

  // Lock next-state: enter on a non-last beat, leave on the owner's last beat.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (any_acc && !beat_last) state_nxt = sel ? LOCK1 : LOCK0;
      LOCK0:   if (acc[0] && beat_last)   state_nxt = IDLE;
      LOCK1:   if (acc[1] && beat_last)   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Lock state, round-robin pointer and chain carry.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      rr_last <= 1'b1;
      chain_c <= 1'b0;
    end else begin
      state <= state_nxt;
      if (any_acc) begin
        rr_last <= sel;
        chain_c <= sum7[6];
      end
    end
  end

  // Single-entry result register: load on accept, clear on drain without refill.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_sum   <= '0;
      res_cout  <= 1'b0;
      res_id    <= 1'b0;
    end else if (any_acc) begin
      res_valid <= 1'b1;
      res_sum   <= sum7[5:0];
      res_cout  <= sum7[6];
      res_id    <= sel;
    end else if (res_ready) begin
      res_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter with a result scoreboard; a second
// instance with fixed priority shares the request inputs.
module tb_adder_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       v0, v1, cin0, cin1, last0, last1, res_ready;
  logic [5:0] a0, b0, a1, b1;
  logic       r0, r1, res_valid, res_cout, res_id, busy;
  logic [5:0] res_sum;
  logic       f_r0, f_r1, f_valid, f_cout, f_id, f_busy;
  logic [5:0] f_sum;

  int nchk = 0;
  int nerr = 0;
  logic [7:0] q[$];   // {id, cout, sum}

  always #5 clk = ~clk;

  adder_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(v0), .req0_ready(r0), .req0_a(a0), .req0_b(b0), .req0_cin(cin0), .req0_last(last0),
    .req1_valid(v1), .req1_ready(r1), .req1_a(a1), .req1_b(b1), .req1_cin(cin1), .req1_last(last1),
    .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum), .res_cout(res_cout),
    .res_id(res_id), .busy(busy)
  );

  adder_arbiter #(.FAIR(1'b0)) dut_fix (
    .clk(clk), .rst(rst),
    .req0_valid(v0), .req0_ready(f_r0), .req0_a(a0), .req0_b(b0), .req0_cin(cin0), .req0_last(last0),
    .req1_valid(v1), .req1_ready(f_r1), .req1_a(a1), .req1_b(b1), .req1_cin(cin1), .req1_last(last1),
    .res_valid(f_valid), .res_ready(1'b1), .res_sum(f_sum), .res_cout(f_cout),
    .res_id(f_id), .busy(f_busy)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push(input logic id, input int a, input int b, input int c);
    int s;
    s = a + b + c;
    q.push_back({id, s[6:0]});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every drained result must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && res_valid && res_ready) begin
      if (q.size() == 0) chk("sb_unexpected", {res_id, res_cout, res_sum}, 16'hFFFF);
      else chk("sb_result", {8'd0, res_id, res_cout, res_sum}, {8'd0, q.pop_front()});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; v0 = 1; v1 = 1; cin0 = 0; cin1 = 0; last0 = 1; last1 = 1; res_ready = 1;
    a0 = 0; b0 = 0; a1 = 0; b1 = 0;
    step(); step();
    @(negedge clk);
    chk("rst_ready0", r0, 0);
    chk("rst_ready1", r1, 0);
    chk("rst_valid", res_valid, 0);
    chk("rst_result", {res_id, res_cout, res_sum}, 0);
    chk("rst_busy", busy, 0);
    step();

    // Single beat 63+1: wraps to 0 with carry-out.
    rst = 0; v1 = 0; v0 = 1; a0 = 63; b0 = 1; cin0 = 0; last0 = 1;
    @(negedge clk);
    chk("single_ready0", r0, 1);
    chk("single_ready1", r1, 0);
    push(0, 63, 1, 0);
    step(); v0 = 0;
    @(negedge clk);
    chk("single_valid", res_valid, 1);
    chk("single_sum", res_sum, 0);
    chk("single_cout", res_cout, 1);
    chk("single_id", res_id, 0);
    step();
    @(negedge clk);
    chk("drain_clears", res_valid, 0);

    // Contention from reset: round-robin alternates, fixed priority stays on 0.
    rst = 1; step(); rst = 0;
    v0 = 1; a0 = 1; b0 = 2; last0 = 1; v1 = 1; a1 = 3; b1 = 4; last1 = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i > 0) chk("fix_id", {f_valid, f_id}, 2'b10);
      chk("rr_ready0", r0, (i % 2 == 0));
      chk("rr_ready1", r1, (i % 2 == 1));
      if (i % 2 == 0) push(0, 1, 2, 0); else push(1, 3, 4, 0);
      step();
    end
    v0 = 0; v1 = 0;
    @(negedge clk);
    chk("fix_id_last", {f_valid, f_id}, 2'b10);
    step();

    // Back-pressure: result held while res_ready=0, req1 blocked.
    res_ready = 0; v0 = 1; a0 = 10; b0 = 2; last0 = 1;
    push(0, 10, 2, 0);
    step();
    v0 = 0; v1 = 1; a1 = 5; b1 = 7; cin1 = 0; last1 = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_ready1", r1, 0);
      chk("hold_result", {res_valid, res_id, res_cout, res_sum}, {1'b1, 1'b0, 1'b0, 6'd12});
      chk("hold_busy", busy, 1);
      step();
    end
    res_ready = 1;
    @(negedge clk);
    chk("drain_ready1", r1, 1);
    push(1, 5, 7, 0);
    step(); v1 = 0;
    @(negedge clk);
    chk("b2b_result", {res_valid, res_id, res_sum}, {1'b1, 1'b1, 6'd12});
    step();

    // Chain on req0 with req1 waiting; the owner pauses mid-chain.
    rst = 1; step(); rst = 0;
    v0 = 1; a0 = 63; b0 = 1; cin0 = 0; last0 = 0;
    v1 = 1; a1 = 2; b1 = 3; cin1 = 1; last1 = 1;
    @(negedge clk);
    chk("chain_ready0", r0, 1);
    chk("chain_ready1", r1, 0);
    push(0, 63, 1, 0);
    step(); v0 = 0;
    @(negedge clk);
    chk("lock_block1", r1, 0);
    chk("lock_busy", busy, 1);
    step();
    @(negedge clk);
    chk("lock_idle_busy", busy, 1);
    chk("lock_block1b", r1, 0);
    step();
    v0 = 1; a0 = 0; b0 = 0; cin0 = 0; last0 = 1;
    @(negedge clk);
    chk("chain2_ready0", r0, 1);
    chk("chain2_ready1", r1, 0);
    push(0, 0, 0, 1);
    step(); v0 = 0;
    @(negedge clk);
    chk("after_chain_ready1", r1, 1);
    push(1, 2, 3, 1);
    step(); v1 = 0;
    step();

    // Reset in LOCK0 with a pending result: both dropped.
    res_ready = 0; v0 = 1; a0 = 10; b0 = 20; cin0 = 0; last0 = 0;
    step(); v0 = 0;
    v1 = 1; a1 = 1; b1 = 1; cin1 = 0; last1 = 1;
    @(negedge clk);
    chk("pre_rst_valid", res_valid, 1);
    chk("pre_rst_ready1", r1, 0);
    rst = 1; step();
    @(negedge clk);
    chk("in_rst_valid", res_valid, 0);
    chk("in_rst_ready1", r1, 0);
    chk("in_rst_busy", busy, 0);
    step();
    rst = 0; res_ready = 1;
    @(negedge clk);
    chk("post_rst_ready1", r1, 1);
    push(1, 1, 1, 0);
    step(); v1 = 0;
    @(negedge clk);
    chk("post_rst_id", {res_valid, res_id, res_sum}, {1'b1, 1'b1, 6'd2});
    step(); step();

    chk("sb_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
